operand_sequencer: RTL

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

---
 rtl/operand_sequencer_pkg.sv | 16 +
 rtl/operand_sequencer_btn_pulse.sv | 41 ++++
 rtl/operand_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/operand_sequencer_pkg.sv
// Shared definitions for the operand sequencer and the comparison stage it feeds.
//   - sequencer state encodings (also driven onto the stage LEDs)
//   - compare-select codes carried on s
package operand_sequencer_pkg;

  localparam logic [1:0] S_X     = 2'd0;
  localparam logic [1:0] S_Y     = 2'd1;
  localparam logic [1:0] S_S     = 2'd2;
  localparam logic [1:0] S_VALID = 2'd3;

  localparam logic [1:0] SEL_EQ  = 2'd0;
  localparam logic [1:0] SEL_GT  = 2'd1;
  localparam logic [1:0] SEL_LT  = 2'd2;
  localparam logic [1:0] SEL_MAX = 2'd3;

endpackage

// File: rtl/operand_sequencer_btn_pulse.sv
// btn_pulse: 2-flop synchronizer plus rising-edge detector for a level button.
// Produces a registered 1-cycle pulse on the 3rd clk edge after the button rises.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   btn   - asynchronous button level
//   pulse - one-cycle pulse per button press
module btn_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;
  logic started;
  logic armed;

  // armed only goes high once the button has been seen low after reset, so a
  // button held through reset release does not count as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      prev    <= 1'b0;
      started <= 1'b0;
      armed   <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      prev    <= sync2;
      started <= 1'b1;
      armed   <= armed | (started & ~sync1);
      pulse   <= sync2 & ~prev & armed;
    end
  end

endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer: collects x, y and a compare select from a shared switch
// bus, one load-button press each, and presents them as a registered operand
// set to the comparison stage with a valid/ready handshake.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   din           - shared switch bus (x, then y, then select)
//   load_btn      - asynchronous load button (level)
//   clear_btn     - asynchronous clear button (level)
//   out_ready     - comparison stage accepts the operand set
//   x, y, s       - registered operands / select to the comparison stage
//   out_valid     - operand set complete
//   stage         - current state, for LEDs
//   txn_count     - number of accepted operand sets (wraps at 256)
//
// state   | meaning
// S_X     | waiting for x
// S_Y     | waiting for y
// S_S     | waiting for select
// S_VALID | operand set presented, waiting for out_ready
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              load_btn,
  input  logic              clear_btn,
  input  logic              out_ready,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  output logic [SEL_W-1:0]  s,
  output logic              out_valid,
  output logic [1:0]        stage,
  output logic [7:0]        txn_count
);

  logic       load_p;
  logic       clear_p;
  logic [1:0] state;

  btn_pulse u_load_pulse (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (load_btn),
    .pulse (load_p)
  );

  btn_pulse u_clear_pulse (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (clear_btn),
    .pulse (clear_p)
  );

  // Decoded straight from the state register: no input reaches out_valid
  // combinationally.
  assign out_valid = (state == S_VALID);
  assign stage     = state;

  // Clear takes priority over both a load and a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_X;
      x         <= '0;
      y         <= '0;
      s         <= '0;
      txn_count <= 8'd0;
    end else if (clear_p) begin
      state <= S_X;
      x     <= '0;
      y     <= '0;
      s     <= '0;
    end else begin
      case (state)
        S_X: begin
          if (load_p) begin
            x     <= din;
            state <= S_Y;
          end
        end
        S_Y: begin
          if (load_p) begin
            y     <= din;
            state <= S_S;
          end
        end
        S_S: begin
          if (load_p) begin
            s     <= din[SEL_W-1:0];
            state <= S_VALID;
          end
        end
        S_VALID: begin
          if (out_valid && out_ready) begin
            txn_count <= txn_count + 8'd1;
            state     <= S_X;
          end
        end
        default: state <= S_X;
      endcase
    end
  end

endmodule
